// File: rtl/etc_pixel_writer.sv
// ETC1 texel writer: decodes one texel (individual or differential mode) of a
// 64-bit block to RGB888 and writes it to the frame buffer, one texel per handshake.
module etc_pixel_writer #(
  parameter int IMG_W     = 128,
  parameter int ADDR_W    = 14,
  parameter int BLK_X_MAX = 31,
  parameter int BLK_Y_MAX = 31
) (
  input  logic              sclk,
  input  logic              rsrt_n,
  input  logic              valid,
  input  logic [63:0]       block_in,
  input  logic [7:0]        blockX,
  input  logic [7:0]        blockY,
  input  logic [4:0]        pixIdx,
  input  logic              fb_ready,
  output logic              write_finish,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [23:0]       fb_data,
  output logic              mode_err,
  output logic              frame_done
);

  typedef enum logic [2:0] {IDLE, DECODE, MODIFY, WRITE, DONE} state_t;
  state_t state_reg, state_next;

  logic [63:0]       blk_reg;
  logic [7:0]        bx_reg, by_reg;
  logic [3:0]        pix_reg;
  logic [23:0]       base_reg;
  logic [2:0]        cw_reg;
  logic              err_reg;
  logic [ADDR_W-1:0] fb_addr_reg;
  logic [23:0]       fb_data_reg;
  logic              mode_err_reg, frame_done_reg;

  logic              capture;
  logic              diff, flip, sub_sel;
  logic [1:0]        tx, ty;
  logic [23:0]       base_next, data_mod;
  logic [2:0]        ovf;
  logic              idx_msb, idx_lsb;
  logic [15:0]       ab;
  logic [7:0]        mag;
  logic [9:0]        mod_val;
  logic [9:0]        px, py;
  logic [ADDR_W-1:0] addr_next;

  assign capture = (state_reg == IDLE) && valid && !pixIdx[4] && !frame_done_reg;

  always_ff @(posedge sclk or negedge rsrt_n) begin
    if (!rsrt_n) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (capture) state_next = DECODE;
      DECODE:  state_next = MODIFY;
      MODIFY:  state_next = WRITE;
      WRITE:   if (fb_ready) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Texel coordinates inside the 4x4 block are column-major in the pixel index.
  assign diff    = blk_reg[33];
  assign flip    = blk_reg[32];
  assign tx      = pix_reg[3:2];
  assign ty      = pix_reg[1:0];
  assign sub_sel = flip ? ty[1] : tx[1];

  // Per-channel base colour decode (R, G, B at byte offsets 0..2) and saturating modify.
  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    localparam int HI = 63 - 8 * gi;
    localparam int OB = 23 - 8 * gi;
    logic [4:0] c5a;
    logic [2:0] dlt;
    logic [5:0] c5b;
    logic [7:0] ind_base, dif_base;
    logic [9:0] sum;

    assign c5a      = blk_reg[HI -: 5];
    assign dlt      = blk_reg[HI-5 -: 3];
    assign c5b      = {1'b0, c5a} + {{3{dlt[2]}}, dlt};
    assign ind_base = sub_sel ? {2{blk_reg[HI-4 -: 4]}} : {2{blk_reg[HI -: 4]}};
    assign dif_base = sub_sel ? {c5b[4:0], c5b[4:2]} : {c5a, c5a[4:2]};
    // Base 2 outside 0..31 marks an ETC2 T/H/planar block.
    assign ovf[gi]  = diff & c5b[5];
    assign base_next[OB -: 8] = diff ? dif_base : ind_base;

    assign sum = {2'b00, base_reg[OB -: 8]} + mod_val;
    assign data_mod[OB -: 8] = sum[9] ? 8'h00 : (sum[8] ? 8'hFF : sum[7:0]);
  end

  function automatic logic [15:0] mod_pair(input logic [2:0] cw);
    case (cw)
      3'd0:    mod_pair = {8'd2,  8'd8};
      3'd1:    mod_pair = {8'd5,  8'd17};
      3'd2:    mod_pair = {8'd9,  8'd29};
      3'd3:    mod_pair = {8'd13, 8'd42};
      3'd4:    mod_pair = {8'd18, 8'd60};
      3'd5:    mod_pair = {8'd24, 8'd80};
      3'd6:    mod_pair = {8'd33, 8'd106};
      default: mod_pair = {8'd47, 8'd183};
    endcase
  endfunction

  assign idx_msb = blk_reg[{2'b01, pix_reg}];
  assign idx_lsb = blk_reg[{2'b00, pix_reg}];
  assign ab      = mod_pair(cw_reg);
  assign mag     = idx_lsb ? ab[7:0] : ab[15:8];
  assign mod_val = idx_msb ? (10'd0 - {2'b00, mag}) : {2'b00, mag};

  assign px        = {bx_reg, tx};
  assign py        = {by_reg, ty};
  assign addr_next = ADDR_W'(32'(py) * 32'(IMG_W) + 32'(px));

  always_ff @(posedge sclk or negedge rsrt_n) begin
    if (!rsrt_n) begin
      blk_reg        <= '0;
      bx_reg         <= '0;
      by_reg         <= '0;
      pix_reg        <= '0;
      base_reg       <= '0;
      cw_reg         <= '0;
      err_reg        <= 1'b0;
      fb_addr_reg    <= '0;
      fb_data_reg    <= '0;
      mode_err_reg   <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (capture) begin
          blk_reg <= block_in;
          bx_reg  <= blockX;
          by_reg  <= blockY;
          pix_reg <= pixIdx[3:0];
        end
        DECODE: begin
          base_reg <= base_next;
          cw_reg   <= sub_sel ? blk_reg[36:34] : blk_reg[39:37];
          err_reg  <= |ovf;
        end
        MODIFY: begin
          fb_addr_reg <= addr_next;
          fb_data_reg <= err_reg ? 24'hFF00FF : data_mod;
          if (err_reg) mode_err_reg <= 1'b1;
        end
        DONE: begin
          if (bx_reg == 8'(BLK_X_MAX) && by_reg == 8'(BLK_Y_MAX) && pix_reg == 4'd15)
            frame_done_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign fb_we        = (state_reg == WRITE);
  assign write_finish = (state_reg == DONE);
  assign fb_addr      = fb_addr_reg;
  assign fb_data      = fb_data_reg;
  assign mode_err     = mode_err_reg;
  assign frame_done   = frame_done_reg;

endmodule

// File: tb/tb_etc_pixel_writer.sv
// Scoreboard bench for etc_pixel_writer: directed texels with hand-decoded
// colours and addresses, stall, reset-in-flight and last-row frame_done run.
module tb_etc_pixel_writer;

  logic        sclk = 1'b0;
  logic        rsrt_n = 1'b0;
  logic        valid = 1'b0;
  logic [63:0] block_in = '0;
  logic [7:0]  blockX = '0;
  logic [7:0]  blockY = '0;
  logic [4:0]  pixIdx = '0;
  logic        fb_ready = 1'b1;
  logic        write_finish, fb_we, mode_err, frame_done;
  logic [13:0] fb_addr;
  logic [23:0] fb_data;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int pushed = 0;

  typedef struct packed {
    logic [13:0] addr;
    logic [23:0] data;
    logic        merr;
  } exp_t;
  exp_t exp_q[$];

  etc_pixel_writer dut (
    .sclk(sclk), .rsrt_n(rsrt_n), .valid(valid), .block_in(block_in),
    .blockX(blockX), .blockY(blockY), .pixIdx(pixIdx), .fb_ready(fb_ready),
    .write_finish(write_finish), .fb_we(fb_we), .fb_addr(fb_addr),
    .fb_data(fb_data), .mode_err(mode_err), .frame_done(frame_done)
  );

  always #5 sclk = ~sclk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write_finish pops one expected write and compares it.
  always @(negedge sclk) begin
    exp_t e;
    if (rsrt_n && write_finish) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0d data %06h expected none", fb_addr, fb_data);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 64'(fb_addr), 64'(e.addr));
        chk("wr_data", 64'(fb_data), 64'(e.data));
        chk("wr_mode_err", 64'(mode_err), 64'(e.merr));
        $display("write addr=%0d data=%06h mode_err=%0b", fb_addr, fb_data, mode_err);
      end
    end
  end

  task automatic start(input logic [63:0] blk, input logic [7:0] bx, input logic [7:0] by,
                       input logic [4:0] pix, input logic push, input logic [13:0] ea,
                       input logic [23:0] ed, input logic em);
    @(negedge sclk);
    valid = 1'b1; block_in = blk; blockX = bx; blockY = by; pixIdx = pix;
    @(posedge sclk);
    #1;
    // Scramble inputs after capture: the DUT must not look at them again.
    valid = 1'b0; block_in = {$urandom, $urandom};
    blockX = 8'($urandom); blockY = 8'($urandom); pixIdx = 5'($urandom_range(0, 15));
    if (push) begin
      exp_q.push_back(exp_t'{addr: ea, data: ed, merr: em});
      pushed++;
    end
  endtask

  task automatic wait_finish(input string name, input bit check_lat);
    int n = 0;
    int we_at = -1;
    while (!write_finish && n < 60) begin
      @(negedge sclk);
      n++;
      if (fb_we && we_at < 0) we_at = n;
    end
    if (!write_finish) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no write_finish after %0d cycles expected one", name, n);
    end else if (check_lat) begin
      chk({name, "_we_latency"}, 64'(we_at), 64'd3);
      chk({name, "_wf_latency"}, 64'(n), 64'd4);
    end
    @(negedge sclk);
    chk({name, "_wf_pulse"}, 64'(write_finish), 64'd0);
  endtask

  initial begin
    int we_seen;
    int n;
    repeat (3) @(negedge sclk);
    chk("rst_we", 64'(fb_we), 64'd0);
    chk("rst_wf", 64'(write_finish), 64'd0);
    chk("rst_addr", 64'(fb_addr), 64'd0);
    chk("rst_data", 64'(fb_data), 64'd0);
    chk("rst_merr", 64'(mode_err), 64'd0);
    chk("rst_fdone", 64'(frame_done), 64'd0);
    rsrt_n = 1'b1;

    // Individual mode, cw 0, index +a, clamps at 255.
    start(64'hF0F0F000_00000000, 8'd0, 8'd0, 5'd0, 1'b1, 14'd0, 24'hFFFFFF, 1'b0);
    wait_finish("t_ind_clamp", 1'b1);
    // Texel 5 with index -a, block (2,1) -> (4+1)*128 + 8+1.
    start(64'hF0F0F000_00200000, 8'd2, 8'd1, 5'd5, 1'b1, 14'd649, 24'hFDFDFD, 1'b0);
    wait_finish("t_ind_neg", 1'b1);
    // Sub-block 1 (x=2), cw2=5, -b: AA-80, 11-80 -> 0, 77-80.
    start(64'h3A51C754_01000100, 8'd3, 8'd2, 5'd8, 1'b1, 14'd1038, 24'h5A0027, 1'b0);
    wait_finish("t_ind_sub1", 1'b1);
    // Sub-block 0 (x=0,y=1), cw1=2, +a.
    start(64'h3A51C754_01000100, 8'd3, 8'd2, 5'd1, 1'b1, 14'd1164, 24'h3C5ED5, 1'b0);
    wait_finish("t_ind_sub0", 1'b1);
    // Differential + flip, texel (0,3) in sub-block 1, cw2=6, +b.
    start(64'h52FD033B_00000008, 8'd5, 8'd7, 5'd3, 1'b1, 14'd3988, 24'hCDFF82, 1'b0);
    wait_finish("t_dif_sub1", 1'b1);
    // Differential, texel 0 in sub-block 0, cw1=1, +a.
    start(64'h52FD033B_00000008, 8'd5, 8'd7, 5'd0, 1'b1, 14'd3604, 24'h57FF05, 1'b0);
    wait_finish("t_dif_sub0", 1'b1);

    // Out-of-range pixel index is ignored.
    @(negedge sclk);
    valid = 1'b1; block_in = 64'hF0F0F000_00000000; pixIdx = 5'd16;
    we_seen = 0;
    repeat (8) begin
      @(negedge sclk);
      if (fb_we || write_finish) we_seen++;
    end
    valid = 1'b0; pixIdx = 5'd0;
    chk("idx16_ignored", 64'(we_seen), 64'd0);

    // Frame-buffer back-pressure.
    fb_ready = 1'b0;
    start(64'hF0F0F000_00200000, 8'd2, 8'd1, 5'd5, 1'b1, 14'd649, 24'hFDFDFD, 1'b0);
    n = 0;
    while (!fb_we && n < 20) begin
      @(negedge sclk);
      n++;
    end
    chk("stall_we_rise", 64'(fb_we), 64'd1);
    repeat (5) begin
      @(negedge sclk);
      chk("stall_we_hold", 64'(fb_we), 64'd1);
      chk("stall_addr_hold", 64'(fb_addr), 64'd649);
      chk("stall_data_hold", 64'(fb_data), 64'hFDFDFD);
      chk("stall_no_wf", 64'(write_finish), 64'd0);
    end
    fb_ready = 1'b1;
    @(negedge sclk);
    chk("stall_wf_after_ready", 64'(write_finish), 64'd1);
    @(negedge sclk);
    chk("stall_wf_pulse", 64'(write_finish), 64'd0);

    // Differential base 2 underflow: flagged, magenta written, write_finish still pulses.
    start(64'h07808002_00000000, 8'd1, 8'd0, 5'd0, 1'b1, 14'd4, 24'hFF00FF, 1'b1);
    wait_finish("t_mode_err", 1'b1);
    chk("merr_sticky", 64'(mode_err), 64'd1);

    // Reset while in MODIFY.
    start(64'hF0F0F000_00200000, 8'd2, 8'd1, 5'd5, 1'b0, 14'd0, 24'h0, 1'b0);
    @(posedge sclk);
    #2;
    rsrt_n = 1'b0;
    #1;
    chk("midrst_we", 64'(fb_we), 64'd0);
    chk("midrst_wf", 64'(write_finish), 64'd0);
    chk("midrst_addr", 64'(fb_addr), 64'd0);
    chk("midrst_data", 64'(fb_data), 64'd0);
    chk("midrst_merr", 64'(mode_err), 64'd0);
    chk("midrst_fdone", 64'(frame_done), 64'd0);
    @(negedge sclk);
    @(negedge sclk);
    rsrt_n = 1'b1;
    start(64'h3A51C754_01000100, 8'd3, 8'd2, 5'd8, 1'b1, 14'd1038, 24'h5A0027, 1'b0);
    wait_finish("t_after_rst", 1'b1);

    // Last block row through a fetcher model; frame_done on the final texel.
    for (int bx = 0; bx < 32; bx++) begin
      for (int p = 0; p < 16; p++) begin
        int x;
        int y;
        logic [23:0] ed;
        x = p >> 2;
        y = p & 3;
        ed = (p == 5) ? 24'hFDFDFD : ((x >= 2) ? 24'h020202 : 24'hFFFFFF);
        start(64'hF0F0F000_00200000, 8'(bx), 8'd31, 5'(p), 1'b1,
              14'((124 + y) * 128 + bx * 4 + x), ed, 1'b0);
        wait_finish("t_frame", 1'b0);
        if (bx == 31 && p == 14) chk("fdone_early", 64'(frame_done), 64'd0);
      end
    end
    chk("fdone_set", 64'(frame_done), 64'd1);

    // After frame_done, valid is ignored.
    @(negedge sclk);
    valid = 1'b1; block_in = 64'hF0F0F000_00000000; blockX = 8'd0; blockY = 8'd0; pixIdx = 5'd0;
    we_seen = 0;
    repeat (10) begin
      @(negedge sclk);
      if (fb_we || write_finish) we_seen++;
    end
    valid = 1'b0;
    chk("no_write_after_done", 64'(we_seen), 64'd0);
    chk("write_count", 64'(wr_count), 64'(pushed));
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test expected finish before 2 ms");
    $fatal(1, "watchdog");
  end

endmodule
